reg_file_rd_port: RTL and testbench

Read-side companion to the two-entry, 16-bit register file. Accepts a read request (register address) over a valid/ready handshake, snapshots the addressed register from the file's flattened output bus, and returns it as a byte stream, MSB byte first, over a second valid/ready handshake. Sits between the register file's flat output and a byte-wide host link.

---
 rtl/reg_file_rd_port_pkg.sv | 20 ++
 rtl/reg_file_word_ser.sv | 41 ++++
 rtl/reg_file_rd_port.sv | 101 ++++++++++
 tb/tb_reg_file_rd_port.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_rd_port_pkg.sv
// Shared definitions for the register-file read port: default geometry,
// FSM state encoding and the position of a register inside the flat bus.
package reg_file_rd_port_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 2;
    localparam int DEF_BYTE_W   = 8;

    // Same encoding the write-side file uses for its own FSM.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // LSB of register idx on the flattened bus; register 0 is the top slice.
    function automatic int slice_lsb(input int idx, input int data_w, input int num_regs);
        return data_w * (num_regs - 1 - idx);
    endfunction

endpackage

// File: rtl/reg_file_word_ser.sv
// Word serializer: parallel-load shift register that presents its top byte,
// plus a byte counter whose zero value marks the final byte of the word.
module reg_file_word_ser #(
    parameter int DATA_W = 16,
    parameter int BYTE_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic [BYTE_W-1:0] byte_data,
    output logic              last
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;

    // Load wins over shift so a back-to-back reload replaces the spent word.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= CNT_W'(NBYTES - 1);
        end else if (shift) begin
            shreg <= shreg << BYTE_W;
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign byte_data = shreg[DATA_W-1 -: BYTE_W];
    assign last      = (cnt == '0);

endmodule

// File: rtl/reg_file_rd_port.sv
// Read port of the register file: accepts an address, snapshots that
// register from the flat bus and streams it out MSB byte first.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; a producer holds valid and its payload steady until
// that edge, and ready may depend combinationally on the other side's valid.
module reg_file_rd_port
    import reg_file_rd_port_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BYTE_W   = DEF_BYTE_W,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_W*NUM_REGS-1:0] a_in,
    input  logic                       rd_req_valid,
    input  logic [ADDR_W-1:0]          rd_req_addr,
    output logic                       rd_req_ready,
    output logic                       rd_byte_valid,
    output logic [BYTE_W-1:0]          rd_byte_data,
    output logic                       rd_byte_last,
    output logic                       rd_byte_err,
    input  logic                       rd_byte_ready,
    output state_t                     dbg_state
);

    state_t state_q;
    state_t state_d;
    logic   err_q;

    logic              hit;
    logic [DATA_W-1:0] snap;
    logic              byte_hs;
    logic              last_hs;
    logic              accept;
    logic              ser_last;

    // Address decode: an unmatched address yields a zero word and the error flag.
    always_comb begin
        hit  = 1'b0;
        snap = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_req_addr == ADDR_W'(i)) begin
                hit  = 1'b1;
                snap = a_in[slice_lsb(i, DATA_W, NUM_REGS) +: DATA_W];
            end
        end
    end

    assign rd_byte_valid = (state_q == SEND);
    assign byte_hs       = rd_byte_valid & rd_byte_ready;
    assign last_hs       = byte_hs & ser_last;
    assign rd_req_ready  = ((state_q == IDLE) | last_hs) & ~reset;
    assign accept        = rd_req_valid & rd_req_ready;

    // Next state: a request taken on the final byte keeps the stream going.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: begin
                if (accept)       state_d = SEND;
                else if (last_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and error flag latched with each accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                err_q <= ~hit;
            end
        end
    end

    reg_file_word_ser #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_ser (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .load_data (snap),
        .shift     (byte_hs & ~accept),
        .byte_data (rd_byte_data),
        .last      (ser_last)
    );

    assign rd_byte_last = rd_byte_valid & ser_last;
    assign rd_byte_err  = rd_byte_valid & err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_reg_file_rd_port.sv
// Directed bench for the register-file read port: a two-register instance
// for the main scenarios and a three-register instance for the error path.
module tb_reg_file_rd_port;
    import reg_file_rd_port_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- two-register instance ----------------
    logic [31:0] a_in;
    logic        rd_req_valid;
    logic [0:0]  rd_req_addr;
    logic        rd_req_ready;
    logic        rd_byte_valid;
    logic [7:0]  rd_byte_data;
    logic        rd_byte_last;
    logic        rd_byte_err;
    logic        rd_byte_ready;
    state_t      dbg_state;

    reg_file_rd_port #(.DATA_W(16), .NUM_REGS(2), .BYTE_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .a_in          (a_in),
        .rd_req_valid  (rd_req_valid),
        .rd_req_addr   (rd_req_addr),
        .rd_req_ready  (rd_req_ready),
        .rd_byte_valid (rd_byte_valid),
        .rd_byte_data  (rd_byte_data),
        .rd_byte_last  (rd_byte_last),
        .rd_byte_err   (rd_byte_err),
        .rd_byte_ready (rd_byte_ready),
        .dbg_state     (dbg_state)
    );

    // ---------------- three-register instance ----------------
    logic [47:0] a_in3;
    logic        rd_req_valid3;
    logic [1:0]  rd_req_addr3;
    logic        rd_req_ready3;
    logic        rd_byte_valid3;
    logic [7:0]  rd_byte_data3;
    logic        rd_byte_last3;
    logic        rd_byte_err3;
    logic        rd_byte_ready3;
    state_t      dbg_state3;

    reg_file_rd_port #(.DATA_W(16), .NUM_REGS(3), .BYTE_W(8)) dut3 (
        .clock         (clock),
        .reset         (reset),
        .a_in          (a_in3),
        .rd_req_valid  (rd_req_valid3),
        .rd_req_addr   (rd_req_addr3),
        .rd_req_ready  (rd_req_ready3),
        .rd_byte_valid (rd_byte_valid3),
        .rd_byte_data  (rd_byte_data3),
        .rd_byte_last  (rd_byte_last3),
        .rd_byte_err   (rd_byte_err3),
        .rd_byte_ready (rd_byte_ready3),
        .dbg_state     (dbg_state3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request that is taken on the next edge (port is idle), then drop valid.
    task automatic issue_req(input logic [0:0] addr);
        rd_req_valid = 1'b1;
        rd_req_addr  = addr;
        step();
        rd_req_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clock);
        n_cmp++; if (rd_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", rd_req_ready); end
        n_cmp++; if (rd_byte_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rd_byte_valid); end
        n_cmp++; if (rd_byte_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", rd_byte_data); end
        n_cmp++; if (rd_byte_last !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b want 0", rd_byte_last); end
        n_cmp++; if (rd_byte_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", rd_byte_err); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rst_state: got %b want IDLE", dbg_state); end
        n_cmp++; if (rd_req_ready3 !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready3: got %b want 0", rd_req_ready3); end
        step();
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (rd_req_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_req_ready: got %b want 1", rd_req_ready); end
        n_cmp++; if (rd_byte_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b want 0", rd_byte_valid); end
        step();
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [2];
        exp_d[0] = 8'hBE; exp_d[1] = 8'hEF;
        a_in = 32'hBEEF_1234;
        rd_byte_ready = 1'b1;
        rd_req_valid = 1'b1;
        rd_req_addr  = 1'b0;
        @(negedge clock);
        n_cmp++; if (rd_req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle_ready: got %b want 1", rd_req_ready); end
        step();
        rd_req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_cmp++; if (rd_byte_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid[%0d]: got %b want 1", k, rd_byte_valid); end
            n_cmp++; if (rd_byte_data !== exp_d[k]) begin n_bad++; $display("FAIL basic_data[%0d]: got %h want %h", k, rd_byte_data, exp_d[k]); end
            n_cmp++; if (rd_byte_last !== (k == 1)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b want %b", k, rd_byte_last, (k == 1)); end
            n_cmp++; if (rd_byte_err !== 1'b0) begin n_bad++; $display("FAIL basic_err[%0d]: got %b want 0", k, rd_byte_err); end
            n_cmp++; if (dbg_state !== SEND) begin n_bad++; $display("FAIL basic_state[%0d]: got %b want SEND", k, dbg_state); end
            step();
        end
        @(negedge clock);
        n_cmp++; if (rd_byte_valid !== 1'b0) begin n_bad++; $display("FAIL basic_end_valid: got %b want 0", rd_byte_valid); end
        step();
    endtask

    task automatic test_stall();
        rd_byte_ready = 1'b0;
        issue_req(1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_cmp++; if (rd_byte_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", k, rd_byte_valid); end
            n_cmp++; if (rd_byte_data !== 8'h12) begin n_bad++; $display("FAIL stall_data[%0d]: got %h want 12", k, rd_byte_data); end
            n_cmp++; if (rd_byte_last !== 1'b0) begin n_bad++; $display("FAIL stall_last[%0d]: got %b want 0", k, rd_byte_last); end
            step();
            if (k == 2) rd_byte_ready = 1'b1;
        end
        @(negedge clock);
        n_cmp++; if (rd_byte_data !== 8'h34) begin n_bad++; $display("FAIL stall_data_b1: got %h want 34", rd_byte_data); end
        n_cmp++; if (rd_byte_last !== 1'b1) begin n_bad++; $display("FAIL stall_last_b1: got %b want 1", rd_byte_last); end
        step();
    endtask

    task automatic test_coherence();
        logic [7:0] exp_d [2];
        exp_d[0] = 8'hBE; exp_d[1] = 8'hEF;
        rd_byte_ready = 1'b1;
        issue_req(1'b0);
        a_in = 32'h0000_0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_cmp++; if (rd_byte_data !== exp_d[k]) begin n_bad++; $display("FAIL coh_data[%0d]: got %h want %h", k, rd_byte_data, exp_d[k]); end
            step();
        end
        a_in = 32'hBEEF_1234;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        logic       exp_r [4];
        exp_d[0] = 8'hBE; exp_d[1] = 8'hEF; exp_d[2] = 8'h12; exp_d[3] = 8'h34;
        exp_r[0] = 1'b0;  exp_r[1] = 1'b1;  exp_r[2] = 1'b0;  exp_r[3] = 1'b1;
        rd_byte_ready = 1'b1;
        rd_req_valid  = 1'b1;
        rd_req_addr   = 1'b0;
        step();
        rd_req_addr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_cmp++; if (rd_byte_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, rd_byte_valid); end
            n_cmp++; if (rd_byte_data !== exp_d[k]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rd_byte_data, exp_d[k]); end
            n_cmp++; if (rd_req_ready !== exp_r[k]) begin n_bad++; $display("FAIL b2b_req_ready[%0d]: got %b want %b", k, rd_req_ready, exp_r[k]); end
            n_cmp++; if (rd_byte_last !== exp_r[k]) begin n_bad++; $display("FAIL b2b_last[%0d]: got %b want %b", k, rd_byte_last, exp_r[k]); end
            step();
            if (k == 2) rd_req_valid = 1'b0;
        end
        @(negedge clock);
        n_cmp++; if (rd_byte_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid: got %b want 0", rd_byte_valid); end
        step();
    endtask

    task automatic test_range_err();
        logic [1:0] addr [2];
        logic [7:0] exp_d [2];
        logic       exp_e [2];
        addr[0] = 2'd3; exp_d[0] = 8'h00; exp_e[0] = 1'b1;
        addr[1] = 2'd2; exp_d[1] = 8'h33; exp_e[1] = 1'b0;
        a_in3 = 48'h1111_2222_3333;
        rd_byte_ready3 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            rd_req_valid3 = 1'b1;
            rd_req_addr3  = addr[r];
            step();
            rd_req_valid3 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clock);
                n_cmp++; if (rd_byte_valid3 !== 1'b1) begin n_bad++; $display("FAIL err_valid[%0d][%0d]: got %b want 1", r, k, rd_byte_valid3); end
                n_cmp++; if (rd_byte_data3 !== exp_d[r]) begin n_bad++; $display("FAIL err_data[%0d][%0d]: got %h want %h", r, k, rd_byte_data3, exp_d[r]); end
                n_cmp++; if (rd_byte_err3 !== exp_e[r]) begin n_bad++; $display("FAIL err_flag[%0d][%0d]: got %b want %b", r, k, rd_byte_err3, exp_e[r]); end
                n_cmp++; if (rd_byte_last3 !== (k == 1)) begin n_bad++; $display("FAIL err_last[%0d][%0d]: got %b want %b", r, k, rd_byte_last3, (k == 1)); end
                step();
            end
        end
        @(negedge clock);
        n_cmp++; if (rd_byte_valid3 !== 1'b0) begin n_bad++; $display("FAIL err_end_valid: got %b want 0", rd_byte_valid3); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d [2];
        exp_d[0] = 8'h12; exp_d[1] = 8'h34;
        rd_byte_ready = 1'b1;
        issue_req(1'b0);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (rd_byte_data !== 8'hBE) begin n_bad++; $display("FAIL mid_first_data: got %h want BE", rd_byte_data); end
        n_cmp++; if (rd_req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_req_ready_in_rst: got %b want 0", rd_req_ready); end
        step();
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (rd_byte_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid_after: got %b want 0", rd_byte_valid); end
        n_cmp++; if (rd_byte_last !== 1'b0) begin n_bad++; $display("FAIL mid_last_after: got %b want 0", rd_byte_last); end
        n_cmp++; if (rd_req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_req_ready_after: got %b want 1", rd_req_ready); end
        step();
        issue_req(1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_cmp++; if (rd_byte_data !== exp_d[k]) begin n_bad++; $display("FAIL mid_next_data[%0d]: got %h want %h", k, rd_byte_data, exp_d[k]); end
            n_cmp++; if (rd_byte_last !== (k == 1)) begin n_bad++; $display("FAIL mid_next_last[%0d]: got %b want %b", k, rd_byte_last, (k == 1)); end
            step();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        a_in           = 32'h0;
        rd_req_valid   = 1'b0;
        rd_req_addr    = 1'b0;
        rd_byte_ready  = 1'b0;
        a_in3          = 48'h0;
        rd_req_valid3  = 1'b0;
        rd_req_addr3   = 2'd0;
        rd_byte_ready3 = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_coherence();
        test_back_to_back();
        test_range_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
